// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-neuron layer blocks:
//   - lif_state_t : control states of the LIF neuron sequencer
//   - IN_WIDTH_DEF / VM_WIDTH_DEF : default datapath widths
//   - sat_max / sat_min : two's-complement saturation limits for a width
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int IN_WIDTH_DEF = 8;
    localparam int VM_WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_REFRACT = 2'd2,
        ST_DONE    = 2'd3
    } lif_state_t;

    // Largest value representable in a signed field of width w.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed field of width w.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/lif_sat_integrate.sv
// -----------------------------------------------------------------------------
// lif_sat_integrate
// Combinational leak-and-integrate step of a LIF neuron:
//   vm_next = sat(vm - (vm >>> LEAK_SHIFT) + sext(sum_in))
// LEAK_SHIFT = 0 means no leak at all (not "leak everything").
// Ports:
//   vm      in  VM_WIDTH  current membrane potential (signed)
//   sum_in  in  IN_WIDTH  weighted input sum for this timestep (signed)
//   vm_next out VM_WIDTH  saturated next membrane potential (signed)
// -----------------------------------------------------------------------------
module lif_sat_integrate
    import snn_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int VM_WIDTH   = VM_WIDTH_DEF,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [VM_WIDTH-1:0] vm,
    input  logic signed [IN_WIDTH-1:0] sum_in,
    output logic signed [VM_WIDTH-1:0] vm_next
);

    // Two guard bits above the wider operand so the sum can never wrap
    // before it is compared against the limits.
    localparam int EW = ((VM_WIDTH > IN_WIDTH) ? VM_WIDTH : IN_WIDTH) + 2;
    localparam logic signed [EW-1:0] HI = EW'(sat_max(VM_WIDTH));
    localparam logic signed [EW-1:0] LO = EW'(sat_min(VM_WIDTH));

    logic signed [VM_WIDTH-1:0] leak;
    logic signed [EW-1:0]       acc;

    always_comb begin
        leak = '0;
        if (LEAK_SHIFT > 0) begin
            leak = vm >>> LEAK_SHIFT;
        end
        acc = EW'(vm) - EW'(leak) + EW'(sum_in);
        if (acc > HI) begin
            vm_next = HI[VM_WIDTH-1:0];
        end else if (acc < LO) begin
            vm_next = LO[VM_WIDTH-1:0];
        end else begin
            vm_next = acc[VM_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron_layer2.sv
// -----------------------------------------------------------------------------
// lif_neuron_layer2
// Leaky integrate-and-fire neuron for the second SNN layer. A start pulse
// opens a window of T_STEPS timesteps; every sum_valid cycle inside the
// window is one timestep. After a spike the neuron ignores REFRACT_STEPS
// timesteps. At the window end a one-cycle done pulse is raised and
// spike_count/vmem hold until the next accepted start.
// sum_valid is a valid-only strobe: there is no ready/backpressure, a sample
// is consumed on every rising edge where sum_valid is high and the neuron is
// in RUN or REFRACT, and dropped otherwise.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse opening a window (ignored unless idle)
//   sum_in       signed weighted spike sum, IN_WIDTH
//   sum_valid    sum_in carries a timestep this cycle
//   spike_out    registered one-cycle spike pulse
//   vmem         membrane potential, VM_WIDTH signed
//   spike_count  spikes in current/last window, saturating
//   busy         high in RUN and REFRACT
//   done         one-cycle pulse at window end
//   state_dbg    current sequencer state, for observation only
// -----------------------------------------------------------------------------
module lif_neuron_layer2
    import snn_pkg::*;
#(
    parameter int IN_WIDTH      = IN_WIDTH_DEF,
    parameter int VM_WIDTH      = VM_WIDTH_DEF,
    parameter int THRESHOLD     = 64,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2,
    parameter int T_STEPS       = 10,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [IN_WIDTH-1:0] sum_in,
    input  logic                       sum_valid,
    output logic                       spike_out,
    output logic signed [VM_WIDTH-1:0] vmem,
    output logic [CNT_WIDTH-1:0]       spike_count,
    output logic                       busy,
    output logic                       done,
    output lif_state_t                 state_dbg
);

    // One spare bit on each counter keeps the widths legal for
    // T_STEPS = 1 and REFRACT_STEPS = 0.
    localparam int SW = $clog2(T_STEPS + 1) + 1;
    localparam int RW = $clog2(REFRACT_STEPS + 1) + 1;
    localparam logic [SW-1:0]              LAST_STEP = SW'(T_STEPS - 1);
    localparam logic [RW-1:0]              REF_LOAD  = RW'(REFRACT_STEPS);
    localparam logic signed [VM_WIDTH-1:0] THR       = VM_WIDTH'(THRESHOLD);

    lif_state_t                 state;
    logic [SW-1:0]              step_cnt;
    logic [RW-1:0]              ref_cnt;
    logic signed [VM_WIDTH-1:0] vm_next;
    logic                       fire;
    logic                       last_step;

    lif_sat_integrate #(
        .IN_WIDTH  (IN_WIDTH),
        .VM_WIDTH  (VM_WIDTH),
        .LEAK_SHIFT(LEAK_SHIFT)
    ) u_integrate (
        .vm     (vmem),
        .sum_in (sum_in),
        .vm_next(vm_next)
    );

    assign fire      = (vm_next >= THR);
    // step_cnt holds the number of timesteps already taken in this window.
    assign last_step = (step_cnt == LAST_STEP);
    assign busy      = (state == ST_RUN) || (state == ST_REFRACT);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            vmem        <= '0;
            spike_count <= '0;
            spike_out   <= 1'b0;
            done        <= 1'b0;
            step_cnt    <= '0;
            ref_cnt     <= '0;
        end else begin
            spike_out <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vmem        <= '0;
                        spike_count <= '0;
                        step_cnt    <= '0;
                        ref_cnt     <= '0;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sum_valid) begin
                        step_cnt <= step_cnt + SW'(1);
                        if (fire) begin
                            vmem      <= '0;
                            spike_out <= 1'b1;
                            if (spike_count != '1) begin
                                spike_count <= spike_count + CNT_WIDTH'(1);
                            end
                            ref_cnt <= REF_LOAD;
                        end else begin
                            vmem <= vm_next;
                        end
                        // Window end takes priority over refractory entry.
                        if (last_step) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (fire && (REFRACT_STEPS != 0)) begin
                            state <= ST_REFRACT;
                        end
                    end
                end
                ST_REFRACT: begin
                    // vmem is already 0 from the spike; the sample is dropped.
                    if (sum_valid) begin
                        step_cnt <= step_cnt + SW'(1);
                        ref_cnt  <= ref_cnt - RW'(1);
                        if (last_step) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (ref_cnt == RW'(1)) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_layer2.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_layer2
// Three neuron instances with different parameter sets share clock and reset:
//   0: defaults
//   1: LEAK_SHIFT=0, THRESHOLD=2047, T_STEPS=20
//   2: THRESHOLD=10, REFRACT_STEPS=0, T_STEPS=6, CNT_WIDTH=2
// One instance is driven at a time; the reference model tracks that one.
// -----------------------------------------------------------------------------
module tb_lif_neuron_layer2;
    import snn_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic              st_i [3];
    logic              v_i  [3];
    logic signed [7:0] s_i  [3];
    logic              spk  [3];
    logic signed [11:0] vm  [3];
    logic              bsy  [3];
    logic              dn   [3];
    lif_state_t        sd   [3];
    logic [7:0]        cnt_a;
    logic [7:0]        cnt_b;
    logic [1:0]        cnt_c;

    lif_neuron_layer2 u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(st_i[0]), .sum_in(s_i[0]),
        .sum_valid(v_i[0]), .spike_out(spk[0]), .vmem(vm[0]),
        .spike_count(cnt_a), .busy(bsy[0]), .done(dn[0]), .state_dbg(sd[0])
    );

    lif_neuron_layer2 #(
        .LEAK_SHIFT(0), .THRESHOLD(2047), .T_STEPS(20)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(st_i[1]), .sum_in(s_i[1]),
        .sum_valid(v_i[1]), .spike_out(spk[1]), .vmem(vm[1]),
        .spike_count(cnt_b), .busy(bsy[1]), .done(dn[1]), .state_dbg(sd[1])
    );

    lif_neuron_layer2 #(
        .THRESHOLD(10), .REFRACT_STEPS(0), .T_STEPS(6), .CNT_WIDTH(2)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(st_i[2]), .sum_in(s_i[2]),
        .sum_valid(v_i[2]), .spike_out(spk[2]), .vmem(vm[2]),
        .spike_count(cnt_c), .busy(bsy[2]), .done(dn[2]), .state_dbg(sd[2])
    );

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    int cur     = 0;
    int cyc     = 0;

    // ---------------- reference model ----------------
    // Parameters of the instance currently driven.
    int p_leak, p_thr, p_ref, p_t, p_cmax;
    // Window bookkeeping in plain integers.
    int m_vm, m_cnt, m_steps, m_ref_left;
    bit m_active;   // window open (neuron busy)
    bit m_in_done;  // neuron is showing its done pulse this cycle
    bit e_spike, e_done;

    task automatic cfg(input int c);
        cur = c;
        case (c)
            0:       begin p_leak = 3; p_thr = 64;   p_ref = 2; p_t = 10; p_cmax = 255; end
            1:       begin p_leak = 0; p_thr = 2047; p_ref = 2; p_t = 20; p_cmax = 255; end
            default: begin p_leak = 3; p_thr = 10;   p_ref = 0; p_t = 6;  p_cmax = 3;   end
        endcase
    endtask

    task automatic model_reset();
        m_vm = 0; m_cnt = 0; m_steps = 0; m_ref_left = 0;
        m_active = 0; m_in_done = 0; e_spike = 0; e_done = 0;
    endtask

    // Effect of one clock edge with the given inputs.
    task automatic model_cycle(input bit st, input bit v, input int s);
        int nv;
        e_spike = 0;
        e_done  = 0;
        if (m_in_done) begin
            m_in_done = 0;
        end else if (!m_active) begin
            if (st) begin
                m_vm = 0; m_cnt = 0; m_steps = 0; m_ref_left = 0; m_active = 1;
            end
        end else if (v) begin
            m_steps++;
            if (m_ref_left > 0) begin
                m_ref_left--;
            end else begin
                nv = m_vm + s;
                if (p_leak > 0) nv = nv - (m_vm >>> p_leak);
                if (nv > 2047)  nv = 2047;
                if (nv < -2048) nv = -2048;
                if (nv >= p_thr) begin
                    m_vm = 0;
                    e_spike = 1;
                    if (m_cnt < p_cmax) m_cnt++;
                    m_ref_left = p_ref;
                end else begin
                    m_vm = nv;
                end
            end
            if (m_steps == p_t) begin
                m_active  = 0;
                m_in_done = 1;
                e_done    = 1;
            end
        end
    endtask

    // ---------------- observation ----------------
    function automatic logic signed [31:0] obs_vm();
        return 32'(vm[cur]);
    endfunction

    function automatic logic signed [31:0] obs_cnt();
        case (cur)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_b);
            default: return 32'(cnt_c);
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d cyc%0d: got %0d expected %0d", tag, cur, cyc, obs, exp);
    endtask

    task automatic check_all();
        chk("vmem",        obs_vm(),              32'(m_vm));
        chk("spike_out",   32'(spk[cur]),         32'(e_spike));
        chk("done",        32'(dn[cur]),          32'(e_done));
        chk("busy",        32'(bsy[cur]),         32'(m_active));
        chk("spike_count", obs_cnt(),             32'(m_cnt));
    endtask

    // ---------------- driver ----------------
    // Inputs are applied 1 time unit after a rising edge and held across
    // the next edge; outputs are checked 1 unit after that edge.
    task automatic cycle(input bit st, input bit v, input int s);
        st_i[cur] = st;
        v_i[cur]  = v;
        s_i[cur]  = 8'(s);
        @(posedge clk);
        #1;
        cyc++;
        st_i[cur] = 1'b0;
        v_i[cur]  = 1'b0;
        s_i[cur]  = '0;
        model_cycle(st, v, s);
        check_all();
    endtask

    function automatic int rand_sum();
        case (cur)
            0:       return int'($urandom_range(0, 80)) - 20;
            1:       return int'($urandom_range(0, 255)) - 128;
            default: return int'($urandom_range(0, 60)) - 30;
        endcase
    endfunction

    task automatic random_window();
        int guard;
        guard = 0;
        cycle(1'b1, 1'($urandom_range(0, 1)), rand_sum());
        while (m_active && guard < 200) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), rand_sum());
            guard++;
        end
        n_total++;
        assert (!m_active) n_pass++;
        else $error("FAIL window_timeout dut%0d: still open after %0d cycles", cur, guard);
        repeat (1 + $urandom_range(0, 2)) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), rand_sum());
        end
    endtask

    // ---------------- stimulus ----------------
    int exp_ramp [3];

    initial begin
        exp_ramp[0] = 20; exp_ramp[1] = 38; exp_ramp[2] = 54;
        for (int i = 0; i < 3; i++) begin
            st_i[i] = 1'b0; v_i[i] = 1'b0; s_i[i] = '0;
        end
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state of every instance.
        for (int c = 0; c < 3; c++) begin
            cfg(c);
            check_all();
        end
        rst_n = 1'b1;

        // Constant drive of 20 with default parameters.
        cfg(0);
        model_reset();
        cycle(1'b1, 1'b0, 0);
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b0, 1'b1, 20);
            if (k <= 3) chk("ramp_vmem", obs_vm(), 32'(exp_ramp[k-1]));
            if (k == 4) chk("first_spike", 32'(spk[0]), 1);
            if (k == 7) chk("post_refract_vmem", obs_vm(), 20);
            if (k == 10) begin
                chk("window_done", 32'(dn[0]), 1);
                chk("window_count", obs_cnt(), 2);
            end
        end
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, 50);

        // sum_valid while idle, then start while busy.
        cycle(1'b0, 1'b1, 100);
        cycle(1'b0, 1'b1, 100);
        chk("idle_vmem_hold", obs_vm(), 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 20);
        cycle(1'b1, 1'b1, 20);
        cycle(1'b1, 1'b0, 0);
        for (int k = 0; k < 40 && m_active; k++) cycle(1'b0, 1'b1, 20);
        chk("busy_start_count", obs_cnt(), 2);
        cycle(1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of a window.
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 20);
        cycle(1'b0, 1'b1, 20);
        v_i[0] = 1'b1;
        s_i[0] = 8'sd20;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vmem",  obs_vm(),         0);
        chk("arst_busy",  32'(bsy[0]),      0);
        chk("arst_spike", 32'(spk[0]),      0);
        chk("arst_done",  32'(dn[0]),       0);
        chk("arst_count", obs_cnt(),        0);
        model_reset();
        @(posedge clk);
        #1;
        v_i[0] = 1'b0;
        s_i[0] = '0;
        rst_n  = 1'b1;
        repeat (4) cycle(1'b0, 1'b1, 100);

        // Negative saturation with no leak.
        cfg(1);
        model_reset();
        cycle(1'b1, 1'b0, 0);
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 1'b1, -128);
            if (k == 16) chk("neg_sat_vmem", obs_vm(), -2048);
            if (k == 20) begin
                chk("neg_sat_done",  32'(dn[1]), 1);
                chk("neg_sat_count", obs_cnt(),  0);
            end
        end
        cycle(1'b0, 1'b0, 0);

        // Counter saturation, no refractory period.
        cfg(2);
        model_reset();
        cycle(1'b1, 1'b0, 0);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b1, 50);
            if (k == 2) chk("no_refract_spike", 32'(spk[2]), 1);
        end
        chk("count_saturated", obs_cnt(), 3);
        cycle(1'b0, 1'b0, 0);

        // Randomized windows across all three configurations.
        for (int w = 0; w < 12; w++) begin
            cfg(w % 3);
            model_reset();
            random_window();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lif_neuron_layer2.md
LIF_NEURON_LAYER2 -- requirements
Module: lif_neuron_layer2

Interface
REQ-001 Parameter IN_WIDTH, default 8, width of the signed weighted-sum input.
REQ-002 Parameter VM_WIDTH, default 12, width of the signed membrane potential.
REQ-003 Parameter THRESHOLD, default 64, signed firing threshold (VM_WIDTH bits).
REQ-004 Parameter LEAK_SHIFT, default 3, leak is vm>>>LEAK_SHIFT; 0 disables leak.
REQ-005 Parameter REFRACT_STEPS, default 2, timesteps ignored after a spike.
REQ-006 Parameter T_STEPS, default 10, timesteps per inference window.
REQ-007 Parameter CNT_WIDTH, default 8, spike counter width.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 start  input  1  one-cycle pulse opening an inference window.
REQ-011 sum_in  input  IN_WIDTH  signed weighted spike sum from the layer-2 MAC.
REQ-012 sum_valid  input  1  sum_in holds one timestep's sum this cycle.
REQ-013 spike_out  output  1  registered one-cycle spike pulse.
REQ-014 vmem  output  VM_WIDTH  current membrane potential (signed).
REQ-015 spike_count  output  CNT_WIDTH  spikes in current/last window.
REQ-016 busy  output  1  high in RUN and REFRACT.
REQ-017 done  output  1  one-cycle pulse at window end.

Function
REQ-018 FSM states SHALL be IDLE, RUN, REFRACT, DONE; DONE lasts exactly one cycle then IDLE.
REQ-019 IDLE + start SHALL clear vmem, spike_count, step and refractory counters, enter RUN next cycle.
REQ-020 start while busy SHALL be ignored; sum_valid in IDLE or DONE SHALL be ignored.
REQ-021 Each sum_valid cycle in RUN or REFRACT SHALL count as one timestep.
REQ-022 RUN timestep: vm_next = sat(vm - (vm>>>LEAK_SHIFT) + sext(sum_in)), clamped to [-2^(VM_WIDTH-1), 2^(VM_WIDTH-1)-1].
REQ-023 If vm_next >= THRESHOLD: vmem<=0, spike_out=1 the following cycle, spike_count+1 (saturating at all-ones), refractory counter<=REFRACT_STEPS, state<=REFRACT (unless window ends).
REQ-024 Otherwise vmem<=vm_next, spike_out=0.
REQ-025 REFRACT timestep: vmem held at 0, sum_in discarded, counter decremented; return to RUN when it reaches 0; REFRACT_STEPS=0 never enters REFRACT.
REQ-026 Latency: vmem/spike_out reflect a timestep one cycle after its sum_valid sample.
REQ-027 On the T_STEPS-th timestep the step SHALL still be evaluated (spike counted), then DONE; done asserted the cycle after that sample, coincident with any final spike_out.
REQ-028 spike_count and vmem SHALL hold after DONE until the next accepted start.
REQ-029 sum_valid absent: no state change, spike_out 0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, vmem=0, spike_count=0, spike_out=0, busy=0, done=0, all counters 0, including mid-window.
REQ-031 After rst_n deassertion the block SHALL wait for a new start.

Structure
REQ-032 State enum, VM_WIDTH/IN_WIDTH defaults and saturation limits SHALL live in shared package snn_pkg.
REQ-033 Saturating leak-integrate datapath SHALL be one sub-module, lif_sat_integrate (combinational), FSM/counters in the top.

Verification
REQ-034 Defaults, start, sum_in=20 every cycle: vmem 20,38,54 then spike on step 4, vmem 0.
REQ-035 Continue REQ-034: steps 5,6 ignored (vmem 0), step 7 vmem=20, spike on step 10, done with spike_count=2.
REQ-036 LEAK_SHIFT=0, THRESHOLD=2047, T_STEPS=20, sum_in=-128: vmem reaches -2048 at step 16, stays -2048, no spikes.
REQ-037 rst_n low at step 3 of REQ-034: all outputs 0 asynchronously; sum_valid afterwards ignored until start.
REQ-038 start pulsed at step 2 while busy, and sum_valid=1 with sum_in=100 in IDLE: no effect on vmem, counters or window.
